guard_word_checker: RTL and testbench

- Sits directly downstream of the guarded unsigned counter. Consumes the counter value plus its even-position and odd-position guard counts.
- Each sample gets two checks:
  - recomputed per-sample popcounts against the supplied guards;
  - the value must equal the previous value + 1, modulo 2^WIDTH.
- Tracks lock state, counts errors with saturation, and raises a sticky alarm at a programmable threshold.

---
 rtl/guard_word_checker.sv | 193 +++++++++++++++++++
 tb/tb_guard_word_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/guard_word_checker.sv
// guard_word_checker: checks samples from the guarded counter.
// Each sample gets two checks: its even/odd guard popcounts are recomputed,
// and its value must be the previous value plus one (wrapping). The block
// tracks lock state, keeps a saturating error count and raises a sticky alarm.
module guard_word_checker #(
  parameter int WIDTH        = 8,
  parameter int GUARD_BITS   = 4,
  parameter int ERR_CNT_W    = 8,
  parameter int ALARM_THRESH = 4,
  parameter int SYNC_LEN     = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_value,
  input  logic [GUARD_BITS-1:0] in_even,
  input  logic [GUARD_BITS-1:0] in_odd,
  input  logic                  clr,
  output logic                  err_pulse,
  output logic                  err_guard,
  output logic                  err_seq,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  alarm,
  output logic [1:0]            state,
  output logic                  locked
);

  localparam int SYNC_W = $clog2(SYNC_LEN + 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] THRESH_V   = ERR_CNT_W'(ALARM_THRESH);
  localparam logic [SYNC_W-1:0]    SYNC_LEN_V = SYNC_W'(SYNC_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_prev;
  logic                   r_have_prev;
  logic [SYNC_W-1:0]      r_sync_cnt;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic                   r_err_guard;
  logic                   r_err_seq;
  logic                   r_alarm;
  logic                   r_err_pulse;

  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       w_prev_nxt;
  logic                   w_have_prev_nxt;
  logic [SYNC_W-1:0]      w_sync_nxt;
  logic [ERR_CNT_W-1:0]   w_count_nxt;
  logic                   w_guard_nxt;
  logic                   w_seq_nxt;
  logic                   w_alarm_nxt;
  logic                   w_pulse_nxt;

  logic [GUARD_BITS-1:0]  w_pop_even;
  logic [GUARD_BITS-1:0]  w_pop_odd;
  logic [WIDTH-1:0]       w_prev_inc;
  logic [ERR_CNT_W-1:0]   w_cnt_inc;
  logic [SYNC_W-1:0]      w_sync_inc;
  logic                   w_guard_err;
  logic                   w_seq_err;
  logic                   w_counted;

  // Recompute the even- and odd-position popcounts of the incoming value.
  always_comb begin
    w_pop_even = '0;
    w_pop_odd  = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      w_pop_even = w_pop_even + GUARD_BITS'(in_value[2*i]);
      w_pop_odd  = w_pop_odd  + GUARD_BITS'(in_value[2*i+1]);
    end
  end

  assign w_prev_inc  = r_prev + 1'b1;
  assign w_guard_err = (w_pop_even != in_even) || (w_pop_odd != in_odd);
  assign w_seq_err   = r_have_prev && (in_value != w_prev_inc);
  assign w_cnt_inc   = (r_err_count == CNT_MAX) ? r_err_count : r_err_count + 1'b1;
  assign w_sync_inc  = r_sync_cnt + 1'b1;

  // Next-state logic: enable handling, per-sample checks, counting, then clr override.
  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_have_prev_nxt = r_have_prev;
    w_sync_nxt      = r_sync_cnt;
    w_count_nxt     = r_err_count;
    w_guard_nxt     = r_err_guard;
    w_seq_nxt       = r_err_seq;
    w_alarm_nxt     = r_alarm;
    w_pulse_nxt     = 1'b0;
    w_counted       = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt     = r_alarm ? ST_ALARM : ST_SYNC;
      w_sync_nxt      = '0;
      w_have_prev_nxt = 1'b0;
    end else if (in_valid) begin
      w_prev_nxt      = in_value;
      w_have_prev_nxt = 1'b1;
      case (r_state)
        ST_SYNC: begin
          w_counted = w_guard_err;
          if (w_guard_err || w_seq_err) begin
            w_sync_nxt = '0;
          end else begin
            w_sync_nxt = w_sync_inc;
            if (w_sync_inc == SYNC_LEN_V) begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          w_counted = w_guard_err || w_seq_err;
          if (w_seq_err) begin
            w_state_nxt = ST_SYNC;
            w_sync_nxt  = '0;
          end
        end
        ST_ALARM: begin
          w_counted = w_guard_err || w_seq_err;
        end
        default: begin
          w_counted = 1'b0;
        end
      endcase

      if (w_counted && !clr) begin
        w_pulse_nxt = 1'b1;
        w_count_nxt = w_cnt_inc;
        w_guard_nxt = r_err_guard | w_guard_err;
        w_seq_nxt   = r_err_seq | w_seq_err;
        if (w_cnt_inc == THRESH_V) begin
          w_state_nxt = ST_ALARM;
          w_alarm_nxt = 1'b1;
        end
      end
    end

    if (clr) begin
      w_count_nxt = '0;
      w_guard_nxt = 1'b0;
      w_seq_nxt   = 1'b0;
      w_alarm_nxt = 1'b0;
      w_pulse_nxt = 1'b0;
      if (w_state_nxt == ST_ALARM) begin
        w_state_nxt = ST_SYNC;
        w_sync_nxt  = '0;
      end
    end
  end

  // State and status registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_sync_cnt  <= '0;
      r_err_count <= '0;
      r_err_guard <= 1'b0;
      r_err_seq   <= 1'b0;
      r_alarm     <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_sync_cnt  <= w_sync_nxt;
      r_err_count <= w_count_nxt;
      r_err_guard <= w_guard_nxt;
      r_err_seq   <= w_seq_nxt;
      r_alarm     <= w_alarm_nxt;
      r_err_pulse <= w_pulse_nxt;
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_guard = r_err_guard;
  assign err_seq   = r_err_seq;
  assign err_count = r_err_count;
  assign alarm     = r_alarm;
  assign state     = r_state;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_guard_word_checker.sv
// Testbench for guard_word_checker: table of directed vectors on a default
// instance, plus hand-written async-reset and saturation sequences.
module tb_guard_word_checker;

  typedef struct {
    logic       en;
    logic       valid;
    logic       clr;
    logic [7:0] value;
    logic [3:0] even;
    logic [3:0] odd;
    logic       pulse;
    logic       guard;
    logic       seq;
    logic [7:0] count;
    logic       alarm;
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_value = 8'd0;
  logic [3:0] in_even = 4'd0;
  logic [3:0] in_odd = 4'd0;
  logic       clr = 1'b0;
  logic       err_pulse;
  logic       err_guard;
  logic       err_seq;
  logic [7:0] err_count;
  logic       alarm;
  logic [1:0] state;
  logic       locked;

  logic       b_enable = 1'b0;
  logic       b_valid = 1'b0;
  logic [7:0] b_value = 8'd0;
  logic [3:0] b_even = 4'd0;
  logic [3:0] b_odd = 4'd0;
  logic       b_clr = 1'b0;
  logic       b_err_pulse;
  logic       b_err_guard;
  logic       b_err_seq;
  logic [1:0] b_err_count;
  logic       b_alarm;
  logic [1:0] b_state;
  logic       b_locked;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  guard_word_checker dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
    .in_value(in_value), .in_even(in_even), .in_odd(in_odd), .clr(clr),
    .err_pulse(err_pulse), .err_guard(err_guard), .err_seq(err_seq),
    .err_count(err_count), .alarm(alarm), .state(state), .locked(locked)
  );

  guard_word_checker #(.ERR_CNT_W(2), .ALARM_THRESH(3)) dutSat (
    .clk(clk), .rstn(rstn), .enable(b_enable), .in_valid(b_valid),
    .in_value(b_value), .in_even(b_even), .in_odd(b_odd), .clr(b_clr),
    .err_pulse(b_err_pulse), .err_guard(b_err_guard), .err_seq(b_err_seq),
    .err_count(b_err_count), .alarm(b_alarm), .state(b_state), .locked(b_locked)
  );

  // Compare one observed value against its expected value and log a mismatch.
  task automatic checkField(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Compare every output of the default instance against a vector's expectations.
  task automatic checkOutput(input int idx, input vec_t v);
    checkField("err_pulse", idx, 32'(err_pulse), 32'(v.pulse));
    checkField("err_guard", idx, 32'(err_guard), 32'(v.guard));
    checkField("err_seq",   idx, 32'(err_seq),   32'(v.seq));
    checkField("err_count", idx, 32'(err_count), 32'(v.count));
    checkField("alarm",     idx, 32'(alarm),     32'(v.alarm));
    checkField("state",     idx, 32'(state),     32'(v.st));
    checkField("locked",    idx, 32'(locked),    32'(v.st == 2'd2));
  endtask

  // Drive one vector on the falling edge, then settle just past the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    enable   = v.en;
    in_valid = v.valid;
    clr      = v.clr;
    in_value = v.value;
    in_even  = v.even;
    in_odd   = v.odd;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic en, input logic valid, input logic c,
                        input logic [7:0] value, input logic [3:0] even, input logic [3:0] odd,
                        input logic pulse, input logic guard, input logic seq,
                        input logic [7:0] count, input logic al, input logic [1:0] st);
    vec_t v;
    v.en = en; v.valid = valid; v.clr = c; v.value = value; v.even = even; v.odd = odd;
    v.pulse = pulse; v.guard = guard; v.seq = seq; v.count = count; v.alarm = al; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t zero;
    int expCnt;

    //      en    vld   clr   value  even  odd   pulse guard seq   count al    st
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h01, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'h02, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2);
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'hA3, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'hA4, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'hA5, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'hA6, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd0);
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'hFC, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'hFD, 4'd4, 4'd3, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'hFE, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'hFF, 4'd4, 4'd4, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'h05, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 2'd1);
    addVec(1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h06, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h07, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h08, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h09, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 2'd3);
    addVec(1'b1, 1'b1, 1'b1, 8'h0A, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h0B, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    addVec(1'b1, 1'b1, 1'b0, 8'h0C, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2);
    addVec(1'b1, 1'b1, 1'b0, 8'h0D, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 2'd2);

    zero.en = 1'b0; zero.valid = 1'b0; zero.clr = 1'b0; zero.value = 8'd0;
    zero.even = 4'd0; zero.odd = 4'd0; zero.pulse = 1'b0; zero.guard = 1'b0;
    zero.seq = 1'b0; zero.count = 8'd0; zero.alarm = 1'b0; zero.st = 2'd0;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput(-1, zero);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] vector table, %0d entries", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    $display("[TB] asynchronous reset while locked");
    #3;
    rstn = 1'b0;
    #1;
    checkOutput(100, zero);
    @(negedge clk);
    enable   = 1'b0;
    in_valid = 1'b0;
    rstn     = 1'b1;

    $display("[TB] saturating counter instance");
    @(negedge clk);
    b_enable = 1'b1;
    @(posedge clk);
    #1;
    checkField("sat_state", 200, 32'(b_state), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_value = 8'(k);
      b_even  = 4'd3;
      b_odd   = 4'd3;
      @(posedge clk);
      #1;
      expCnt = (k + 1 > 3) ? 3 : k + 1;
      checkField("sat_count", 201 + k, 32'(b_err_count), 32'(expCnt));
      checkField("sat_pulse", 201 + k, 32'(b_err_pulse), 32'd1);
      checkField("sat_alarm", 201 + k, 32'(b_alarm),     (k >= 2) ? 32'd1 : 32'd0);
      checkField("sat_state", 201 + k, 32'(b_state),     (k >= 2) ? 32'd3 : 32'd1);
    end
    @(negedge clk);
    b_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
